// File: rtl/qos_pkg.sv
// Shared QoS types: per-request QoS tag, arbitration priority key and arbiter FSM states.
package qos_pkg;

  localparam int unsigned QOS_ARB_WAIT_W = 16;

  typedef enum logic [1:0] {
    QOS_LEVEL_LOW      = 2'd0,
    QOS_LEVEL_MEDIUM   = 2'd1,
    QOS_LEVEL_HIGH     = 2'd2,
    QOS_LEVEL_CRITICAL = 2'd3
  } qos_level_e;

  // Per-request QoS tag produced in each core.
  typedef struct packed {
    logic                      urgent;
    qos_level_e                qos_level;
    logic [QOS_ARB_WAIT_W-1:0] max_latency_cycles;
  } qos_config_t;

  localparam int unsigned QOS_CFG_W = $bits(qos_config_t);

  // Arbitration key; compared unsigned, highest wins.
  typedef struct packed {
    logic       urgent_or_escalated;
    qos_level_e qos_level;
  } qos_prio_key_t;

  localparam int unsigned QOS_KEY_W = $bits(qos_prio_key_t);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } qos_arb_state_e;

  // Build the priority key from a tag and its deadline-escalation flag.
  function automatic qos_prio_key_t qos_make_key(input qos_config_t cfg, input logic escalated);
    qos_prio_key_t k;
    k.urgent_or_escalated = cfg.urgent | escalated;
    k.qos_level           = cfg.qos_level;
    return k;
  endfunction

endpackage

// File: rtl/qos_rr_prio_select.sv
// Combinational highest-key selector with round-robin tie-break starting after rr_ptr_i.
module qos_rr_prio_select
  import qos_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned KEY_W = QOS_KEY_W,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]       cand_i,
  input  logic [N*KEY_W-1:0] key_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_valid_o
);

  // Scan in round-robin order; a strictly larger key replaces the current best, so the
  // first candidate in rotation order wins among equal keys.
  always_comb begin
    logic [KEY_W-1:0] best_key;
    logic [KEY_W-1:0] cur_key;
    int unsigned      idx;
    win_idx_o   = '0;
    any_valid_o = 1'b0;
    best_key    = '0;
    cur_key     = '0;
    idx         = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = 32'(rr_ptr_i) + off;
      if (idx >= N) idx = idx - N;
      cur_key = key_i[idx*KEY_W +: KEY_W];
      if (cand_i[idx] && (!any_valid_o || (cur_key > best_key))) begin
        any_valid_o = 1'b1;
        best_key    = cur_key;
        win_idx_o   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/qos_request_arbiter.sv
// QoS request arbiter in front of the shared memory port: picks one of NUM_REQ
// valid/ready streams by urgency, QoS level, deadline escalation and round-robin.
// Optional statistics outputs (lat_viol_cnt_o, max_wait_o) under QOS_ARB_STATS_EN.
module qos_request_arbiter
  import qos_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 64,
  parameter  int unsigned WAIT_W  = QOS_ARB_WAIT_W,
  localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          qos_enable_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
  input  logic [NUM_REQ*QOS_CFG_W-1:0]  req_qos_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [QOS_CFG_W-1:0]          out_qos_o,
  output logic [SRC_W-1:0]              out_src_o
`ifdef QOS_ARB_STATS_EN
  ,
  output logic [31:0]                   lat_viol_cnt_o,
  output logic [WAIT_W-1:0]             max_wait_o
`endif
);

  qos_arb_state_e           state_q, state_d;
  logic [SRC_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  qos_config_t              out_qos_q, out_qos_d;
  logic [SRC_W-1:0]         out_src_q, out_src_d;
  logic [WAIT_W-1:0]        wait_q [NUM_REQ];
  logic [WAIT_W-1:0]        wait_d [NUM_REQ];

  qos_config_t              cfg [NUM_REQ];
  logic [NUM_REQ-1:0]       escalated;
  logic [NUM_REQ*QOS_KEY_W-1:0] key_vec;
  logic [NUM_REQ-1:0]       slot_mask;
  logic [NUM_REQ-1:0]       cand;
  logic                     pop;
  logic [SRC_W-1:0]         sel_ptr;
  logic [SRC_W-1:0]         win_idx;
  logic                     win_any;

  // Unpack tags and form per-requester keys; keys collapse to zero when QoS is off.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_key
    assign cfg[g]       = qos_config_t'(req_qos_i[g*QOS_CFG_W +: QOS_CFG_W]);
    assign escalated[g] = qos_enable_i
                          && (cfg[g].max_latency_cycles != '0)
                          && (wait_q[g] >= WAIT_W'(cfg[g].max_latency_cycles));
    assign key_vec[g*QOS_KEY_W +: QOS_KEY_W] =
        qos_enable_i ? qos_make_key(cfg[g], escalated[g]) : '0;
  end

  // The loaded requester is never a candidate; on pop the rotation restarts after it.
  assign slot_mask   = (state_q == HOLD) ? (NUM_REQ'(1) << out_src_q) : '0;
  assign pop         = (state_q == HOLD) && out_valid_q && out_ready_i;
  assign req_ready_o = pop ? slot_mask : '0;
  assign cand        = req_valid_i & ~slot_mask;
  assign sel_ptr     = pop ? out_src_q : rr_ptr_q;

  qos_rr_prio_select #(
    .N     (NUM_REQ),
    .KEY_W (QOS_KEY_W),
    .IDX_W (SRC_W)
  ) u_select (
    .cand_i      (cand),
    .key_i       (key_vec),
    .rr_ptr_i    (sel_ptr),
    .win_idx_o   (win_idx),
    .any_valid_o (win_any)
  );

  // Next-state and output-slot logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_qos_d   = out_qos_q;
    out_src_d   = out_src_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          out_valid_d = 1'b1;
          out_data_d  = req_data_i[32'(win_idx)*DATA_W +: DATA_W];
          out_qos_d   = cfg[win_idx];
          out_src_d   = win_idx;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (pop) begin
          rr_ptr_d = out_src_q;
          if (win_any) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data_i[32'(win_idx)*DATA_W +: DATA_W];
            out_qos_d   = cfg[win_idx];
            out_src_d   = win_idx;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-requester wait counters: count while waiting, clear on pop or idle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (!req_valid_i[i] || req_ready_o[i]) begin
        wait_d[i] = '0;
      end else if (!(&wait_q[i])) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  // State, pointer, output slot and wait counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_qos_q   <= '0;
      out_src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_qos_q   <= out_qos_d;
      out_src_q   <= out_src_d;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_qos_o   = out_qos_q;
  assign out_src_o   = out_src_q;

`ifdef QOS_ARB_STATS_EN
  logic [31:0]       lat_viol_cnt_q, lat_viol_cnt_d;
  logic [WAIT_W-1:0] max_wait_q, max_wait_d;
  logic [WAIT_W-1:0] pop_wait;
  logic              pop_viol;

  assign pop_wait = wait_q[out_src_q];
  assign pop_viol = pop
                    && (out_qos_q.max_latency_cycles != '0)
                    && (pop_wait >= WAIT_W'(out_qos_q.max_latency_cycles));

  // Saturating deadline-violation count and running maximum wait at pop.
  always_comb begin
    lat_viol_cnt_d = lat_viol_cnt_q;
    max_wait_d     = max_wait_q;
    if (pop_viol && !(&lat_viol_cnt_q)) lat_viol_cnt_d = lat_viol_cnt_q + 32'd1;
    if (pop && (pop_wait > max_wait_q)) max_wait_d = pop_wait;
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_viol_cnt_q <= '0;
      max_wait_q     <= '0;
    end else begin
      lat_viol_cnt_q <= lat_viol_cnt_d;
      max_wait_q     <= max_wait_d;
    end
  end

  assign lat_viol_cnt_o = lat_viol_cnt_q;
  assign max_wait_o     = max_wait_q;
`endif

endmodule

// File: tb/tb_qos_request_arbiter.sv
// Scoreboard bench for qos_request_arbiter: directed requester queues, expected grants
// queued by the stimulus and compared by an independent monitor at each transfer.
module tb_qos_request_arbiter;
  import qos_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned WW = QOS_ARB_WAIT_W;
  localparam int unsigned SW = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   qos_enable;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N*DW-1:0]        req_data;
  logic [N*QOS_CFG_W-1:0] req_qos;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW-1:0]          out_data;
  logic [QOS_CFG_W-1:0]   out_qos;
  logic [SW-1:0]          out_src;
`ifdef QOS_ARB_STATS_EN
  logic [31:0]            lat_viol_cnt;
  logic [WW-1:0]          max_wait;
`endif

  always #5 clk = ~clk;

  qos_request_arbiter #(.NUM_REQ(N), .DATA_W(DW), .WAIT_W(WW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .qos_enable_i (qos_enable),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .req_qos_i    (req_qos),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_qos_o    (out_qos),
    .out_src_o    (out_src)
`ifdef QOS_ARB_STATS_EN
    ,
    .lat_viol_cnt_o (lat_viol_cnt),
    .max_wait_o     (max_wait)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    qos_config_t   qos;
  } txn_t;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
    qos_config_t   qos;
  } exp_t;

  txn_t        req_q [N][$];
  exp_t        exp_q [$];
  qos_config_t cfg_of [N];
  logic [N-1:0] fire_s = '0;
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] mkdata(int src, int seq);
    return 64'hD0DA_0000_0000_0000 | (64'(src) << 16) | 64'(seq);
  endfunction

  function automatic qos_config_t mkcfg(qos_level_e lvl, logic urg, logic [WW-1:0] max_lat);
    qos_config_t c;
    c.urgent             = urg;
    c.qos_level          = lvl;
    c.max_latency_cycles = max_lat;
    return c;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive requester pins from the head of each requester queue.
  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (req_q[i].size() != 0);
      if (req_q[i].size() != 0) begin
        req_data[i*DW +: DW]               = req_q[i][0].data;
        req_qos[i*QOS_CFG_W +: QOS_CFG_W]  = req_q[i][0].qos;
      end else begin
        req_data[i*DW +: DW]               = '0;
        req_qos[i*QOS_CFG_W +: QOS_CFG_W]  = '0;
      end
    end
  endtask

  task automatic push_req(int src, int seq);
    txn_t t;
    t.data = mkdata(src, seq);
    t.qos  = cfg_of[src];
    req_q[src].push_back(t);
    apply_inputs();
  endtask

  task automatic push_exp(int src, int seq);
    exp_t e;
    e.src  = SW'(src);
    e.data = mkdata(src, seq);
    e.qos  = cfg_of[src];
    exp_q.push_back(e);
  endtask

  // Requester model: record ready away from the edge, pop after the edge.
  always @(negedge clk) fire_s = req_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (fire_s[i] && (req_q[i].size() != 0)) void'(req_q[i].pop_front());
    apply_inputs();
  end

  // Monitor: every downstream transfer is compared with the next expected grant.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_grant: got src %0d, required no transfer", out_src);
      end else begin
        exp_t e;
        logic [N-1:0] oh;
        e  = exp_q.pop_front();
        oh = '0;
        oh[e.src] = 1'b1;
        check("grant_src",  64'(out_src),   64'(e.src));
        check("grant_data", out_data,       e.data);
        check("grant_qos",  64'(out_qos),   64'(e.qos));
        check("pop_ready",  64'(req_ready), 64'(oh));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(bit chk);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) req_q[i].delete();
    exp_q.delete();
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    if (chk) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_out_data",  out_data,       64'd0);
      check("rst_out_src",   64'(out_src),   64'd0);
      check("rst_out_qos",   64'(out_qos),   64'd0);
`ifdef QOS_ARB_STATS_EN
      check("rst_lat_viol",  64'(lat_viol_cnt), 64'd0);
      check("rst_max_wait",  64'(max_wait),     64'd0);
`endif
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Wait for all expected grants, then require the slot to be empty.
  task automatic wait_drain(string name, int budget);
    int k = 0;
    while ((exp_q.size() != 0) && (k < budget)) begin
      tick();
      k++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check({name, "_idle_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    qos_enable = 1'b1;
    out_ready  = 1'b0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_qos    = '0;

    // Single requester: one-cycle latency, pop pulses req_ready[0].
    do_reset(1'b1);
    for (int i = 0; i < N; i++) cfg_of[i] = mkcfg(QOS_LEVEL_HIGH, 1'b0, '0);
    out_ready = 1'b1;
    push_req(0, 0);
    push_exp(0, 0);
    @(negedge clk);
    check("single_latency_cycle0", 64'(out_valid), 64'd0);
    tick();
    check("single_valid_cycle1", 64'(out_valid), 64'd1);
    check("single_src",          64'(out_src),   64'd0);
    check("single_ready_onehot", 64'(req_ready), 64'b0001);
    wait_drain("single", 10);

    // Level priority: CRITICAL before MEDIUM, back to back.
    do_reset(1'b0);
    cfg_of[1] = mkcfg(QOS_LEVEL_MEDIUM, 1'b0, '0);
    cfg_of[2] = mkcfg(QOS_LEVEL_CRITICAL, 1'b0, '0);
    out_ready = 1'b1;
    push_req(1, 0);
    push_req(2, 0);
    push_exp(2, 0);
    push_exp(1, 0);
    tick();
    check("level_first_src", 64'(out_src), 64'd2);
    tick();
    check("level_no_bubble", 64'(out_valid), 64'd1);
    check("level_second_src", 64'(out_src), 64'd1);
    wait_drain("level", 10);

    // Round-robin among equal keys, continuously valid.
    do_reset(1'b0);
    for (int i = 0; i < N; i++) cfg_of[i] = mkcfg(QOS_LEVEL_HIGH, 1'b0, '0);
    out_ready = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) push_req(i, s);
    for (int s = 0; s < 2; s++) begin
      push_exp(1, s);
      push_exp(2, s);
      push_exp(3, s);
      push_exp(0, s);
    end
    wait_drain("rr", 20);

    // Escalation: MEDIUM req0 (deadline 5) overtakes HIGH req2/req3 once its wait reaches 5.
    do_reset(1'b0);
    cfg_of[0] = mkcfg(QOS_LEVEL_MEDIUM, 1'b0, WW'(5));
    cfg_of[2] = mkcfg(QOS_LEVEL_HIGH, 1'b0, '0);
    cfg_of[3] = mkcfg(QOS_LEVEL_HIGH, 1'b0, '0);
    push_req(0, 0);
    for (int s = 0; s < 3; s++) push_req(2, s);
    for (int s = 0; s < 2; s++) push_req(3, s);
    push_exp(2, 0);
    push_exp(3, 0);
    push_exp(2, 1);
    push_exp(0, 0);
    push_exp(2, 2);
    push_exp(3, 1);
    for (int c = 0; (c < 30) && (exp_q.size() != 0); c++) begin
      out_ready = (c % 2) == 1;
      tick();
    end
    out_ready = 1'b1;
    wait_drain("escalate", 10);
`ifdef QOS_ARB_STATS_EN
    check("stats_lat_viol", 64'(lat_viol_cnt), 64'd1);
    check("stats_max_wait", 64'(max_wait),     64'd7);
`endif

    // Backpressure: slot held stable for 10 cycles, then a single pop.
    do_reset(1'b0);
    cfg_of[1] = mkcfg(QOS_LEVEL_LOW, 1'b0, '0);
    push_req(1, 0);
    push_exp(1, 0);
    tick();
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data",  out_data,       mkdata(1, 0));
      check("bp_src",   64'(out_src),   64'd1);
      check("bp_ready", 64'(req_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("bp", 5);

    // QoS disabled: plain round-robin ignores urgency, req1 before urgent req2.
    do_reset(1'b0);
    qos_enable = 1'b0;
    cfg_of[1] = mkcfg(QOS_LEVEL_LOW, 1'b0, '0);
    cfg_of[2] = mkcfg(QOS_LEVEL_CRITICAL, 1'b1, '0);
    out_ready = 1'b1;
    push_req(2, 0);
    push_req(1, 0);
    push_exp(1, 0);
    push_exp(2, 0);
    wait_drain("qos_off", 10);
    qos_enable = 1'b1;

    // Reset while holding: slot dropped without a pop, request granted after reset.
    do_reset(1'b0);
    cfg_of[3] = mkcfg(QOS_LEVEL_LOW, 1'b0, '0);
    push_req(3, 0);
    tick();
    check("midrst_loaded", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_dropped", 64'(out_valid), 64'd0);
    check("midrst_no_pop",  64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    push_exp(3, 0);
    out_ready = 1'b1;
    wait_drain("midrst", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
